// File: rtl/pll_sync_tracker_if.sv
// pll_sync_tracker_if
// Groups the reference input and the phase/lock outputs of pll_sync_tracker.
//   ref_lvl  : slow-clock reference level, already synchronous to clk.
//              ("ref" is a reserved word in SystemVerilog, hence the name.)
//   ctr      : modulo-RATIO phase counter, 0..RATIO-1
//   phase0   : high while ctr == 0
//   locked   : tracker is in the LOCKED state
//   period   : last measured rising-edge spacing in clk cycles
//   err      : one-cycle pulse on each bad period or timeout
//   err_cnt  : saturating err pulse count, present only when
//              PLL_SYNC_TRACKER_ERR_CNT_EN is defined
// Modports: master = the side that supplies the reference and consumes the
// outputs; slave = the tracker itself.
interface pll_sync_tracker_if #(
  parameter int RATIO = 8
) ();
  localparam int CW = $clog2(RATIO);
  localparam int PW = $clog2(2 * RATIO) + 1;

  logic          ref_lvl;
  logic [CW-1:0] ctr;
  logic          phase0;
  logic          locked;
  logic [PW-1:0] period;
  logic          err;
`ifdef PLL_SYNC_TRACKER_ERR_CNT_EN
  logic [15:0]   err_cnt;

  modport master (output ref_lvl, input ctr, phase0, locked, period, err, err_cnt);
  modport slave  (input ref_lvl, output ctr, phase0, locked, period, err, err_cnt);
`else
  modport master (output ref_lvl, input ctr, phase0, locked, period, err);
  modport slave  (input ref_lvl, output ctr, phase0, locked, period, err);
`endif
endinterface

// File: rtl/pll_sync_tracker.sv
// pll_sync_tracker
// Tracks a slow reference clock from the fast clock domain. Produces a
// modulo-RATIO phase counter aligned to reference rising edges, measures the
// spacing of consecutive rising edges, flags bad periods and missing edges,
// and runs a lock state machine with entry/exit hysteresis.
// Ports:
//   clk  : fast clock, all logic on posedge
//   rst  : synchronous, active-high reset
//   bus  : pll_sync_tracker_if.slave (ref_lvl in; ctr, phase0, locked,
//          period, err and optional err_cnt out)
// Optional feature macro: PLL_SYNC_TRACKER_ERR_CNT_EN adds a 16-bit
// saturating count of err pulses on bus.err_cnt.
module pll_sync_tracker #(
  parameter int RATIO      = 8,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  pll_sync_tracker_if.slave     bus
);
  localparam int CW  = $clog2(RATIO);
  localparam int PW  = $clog2(2 * RATIO) + 1;
  localparam int TMO = 2 * RATIO;
  localparam int GW  = $clog2(LOCK_CNT + 1);
  localparam int BW  = $clog2(UNLOCK_CNT + 1);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_ACQUIRE  = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  logic          ref_q;
  logic [CW-1:0] ctr_q,      ctr_d;
  logic          phase0_q,   phase0_d;
  logic          locked_q,   locked_d;
  logic [PW-1:0] period_q,   period_d;
  logic          err_q,      err_d;
  logic [PW-1:0] per_ctr_q,  per_ctr_d;
  logic [1:0]    state_q,    state_d;
  logic          first_seen_q, first_seen_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic [BW-1:0] bad_cnt_q,  bad_cnt_d;

  logic          rise;
  logic          timeout;
  logic          evaluate;
  logic          good;
  logic          bad;
  logic [GW-1:0] good_inc;
  logic [BW-1:0] bad_inc;

  always_comb begin
    rise     = bus.ref_lvl & ~ref_q;
    // The rise cycle itself is phase 0, so the counter restarts at 1.
    ctr_d    = rise ? CW'(1)
             : (ctr_q == CW'(RATIO - 1)) ? '0
             : ctr_q + CW'(1);
    phase0_d = (ctr_d == '0);

    per_ctr_d = rise ? PW'(1)
              : (per_ctr_q == PW'(TMO)) ? per_ctr_q
              : per_ctr_q + PW'(1);

    // first_seen doubles as the timeout arm: it is set by a rise and cleared
    // by a timeout, so one missing-edge episode yields one timeout, and no
    // timeout can occur before the very first edge after reset.
    timeout  = ~rise & first_seen_q & (per_ctr_q == PW'(TMO - 1));
    evaluate = rise & first_seen_q;
    good     = evaluate & (per_ctr_q == PW'(RATIO));
    bad      = evaluate & ~good;

    first_seen_d = rise ? 1'b1 : (timeout ? 1'b0 : first_seen_q);
    period_d     = evaluate ? per_ctr_q : period_q;
    err_d        = bad | timeout;

    good_inc   = good_cnt_q + GW'(1);
    bad_inc    = bad_cnt_q + BW'(1);
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;

    case (state_q)
      ST_UNLOCKED: begin
        if (rise) begin
          state_d    = ST_ACQUIRE;
          good_cnt_d = '0;
        end
      end
      ST_ACQUIRE: begin
        if (good) begin
          good_cnt_d = good_inc;
          if (good_inc == GW'(LOCK_CNT)) begin
            state_d   = ST_LOCKED;
            bad_cnt_d = '0;
          end
        end else if (bad) begin
          good_cnt_d = '0;
        end else if (timeout) begin
          state_d = ST_UNLOCKED;
        end
      end
      ST_LOCKED: begin
        if (good) begin
          bad_cnt_d = '0;
        end else if (bad || timeout) begin
          bad_cnt_d = bad_inc;
          if (bad_inc == BW'(UNLOCK_CNT)) begin
            state_d    = rise ? ST_ACQUIRE : ST_UNLOCKED;
            good_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_UNLOCKED;
      end
    endcase

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q        <= 1'b0;
      ctr_q        <= '0;
      phase0_q     <= 1'b1;
      locked_q     <= 1'b0;
      period_q     <= '0;
      err_q        <= 1'b0;
      per_ctr_q    <= '0;
      state_q      <= ST_UNLOCKED;
      first_seen_q <= 1'b0;
      good_cnt_q   <= '0;
      bad_cnt_q    <= '0;
    end else begin
      ref_q        <= bus.ref_lvl;
      ctr_q        <= ctr_d;
      phase0_q     <= phase0_d;
      locked_q     <= locked_d;
      period_q     <= period_d;
      err_q        <= err_d;
      per_ctr_q    <= per_ctr_d;
      state_q      <= state_d;
      first_seen_q <= first_seen_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
    end
  end

  assign bus.ctr    = ctr_q;
  assign bus.phase0 = phase0_q;
  assign bus.locked = locked_q;
  assign bus.period = period_q;
  assign bus.err    = err_q;

`ifdef PLL_SYNC_TRACKER_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Counts alongside err so both become visible in the same cycle.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_pll_sync_tracker.sv
// tb_pll_sync_tracker
// Directed bench for pll_sync_tracker with RATIO=8, LOCK_CNT=4, UNLOCK_CNT=2.
// Inputs change and outputs are sampled on the falling clock edge. When
// PLL_SYNC_TRACKER_ERR_CNT_EN is defined the err_cnt output is also checked.
module tb_pll_sync_tracker;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   err_seen;

  pll_sync_tracker_if #(.RATIO(8)) bus ();

  pll_sync_tracker #(
    .RATIO      (8),
    .LOCK_CNT   (4),
    .UNLOCK_CNT (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle with ref_lvl = r sampled at the rising edge.
  task automatic cyc(input logic r);
    bus.ref_lvl = r;
    @(negedge clk);
    if (bus.err === 1'b1) err_seen++;
  endtask

  // Remaining n-1 cycles of a period of n that began with a rise.
  task automatic finish_period(input int n);
    for (int i = 1; i < n; i++) cyc(i < n / 2);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    err_seen    = 0;
    rst         = 1'b1;
    bus.ref_lvl = 1'b0;
    @(negedge clk);
    cyc(1'b0);
    chk("rst_ctr",    32'(bus.ctr),    32'd0);
    chk("rst_phase0", 32'(bus.phase0), 32'd1);
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_period", 32'(bus.period), 32'd0);
    chk("rst_err",    32'(bus.err),    32'd0);
`ifdef PLL_SYNC_TRACKER_ERR_CNT_EN
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
`endif
    rst = 1'b0;

    // No timeout before the first edge, even with per_ctr saturated.
    repeat (18) cyc(1'b0);
    chk("idle_no_err", 32'(err_seen), 32'd0);

    // Acquire: rises 1..5 at period 8; the 5th period is cut to 6.
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b1);
      chk("acq_ctr_after_rise", 32'(bus.ctr), 32'd1);
      chk("acq_phase0_after_rise", 32'(bus.phase0), 32'd0);
      chk("acq_locked", 32'(bus.locked), (k == 5) ? 32'd1 : 32'd0);
      if (k == 2) chk("acq_period", 32'(bus.period), 32'd8);
      finish_period((k == 5) ? 6 : 8);
      if (k == 1) begin
        chk("wrap_ctr", 32'(bus.ctr), 32'd0);
        chk("wrap_phase0", 32'(bus.phase0), 32'd1);
      end
    end
    chk("acq_no_err", 32'(err_seen), 32'd0);

    // Early rise (period 6): one err, still locked, ctr realigned.
    cyc(1'b1);
    chk("early_period", 32'(bus.period), 32'd6);
    chk("early_err",    32'(bus.err),    32'd1);
    chk("early_locked", 32'(bus.locked), 32'd1);
    chk("early_ctr",    32'(bus.ctr),    32'd1);
    finish_period(8);
    cyc(1'b1);
    chk("good_after_early_err",    32'(bus.err),    32'd0);
    chk("good_after_early_period", 32'(bus.period), 32'd8);
    chk("good_after_early_locked", 32'(bus.locked), 32'd1);
    finish_period(9);

    // Two periods of 9: the second one drops lock.
    cyc(1'b1);
    chk("long1_period", 32'(bus.period), 32'd9);
    chk("long1_err",    32'(bus.err),    32'd1);
    chk("long1_locked", 32'(bus.locked), 32'd1);
    finish_period(9);
    cyc(1'b1);
    chk("long2_err",    32'(bus.err),    32'd1);
    chk("long2_locked", 32'(bus.locked), 32'd0);
    finish_period(8);
    for (int j = 1; j <= 4; j++) begin
      cyc(1'b1);
      chk("relock_locked", 32'(bus.locked), (j == 4) ? 32'd1 : 32'd0);
      finish_period(8);
    end

    // ref held low: per_ctr is 8 here and reaches 16 after 8 more cycles.
    repeat (7) cyc(1'b0);
    chk("tmo_not_yet", 32'(bus.err), 32'd0);
    cyc(1'b0);
    chk("tmo_err",    32'(bus.err),    32'd1);
    chk("tmo_locked", 32'(bus.locked), 32'd1);
    repeat (16) cyc(1'b0);
    chk("tmo_single_pulse", 32'(err_seen), 32'd4);
    chk("tmo_still_locked", 32'(bus.locked), 32'd1);
    cyc(1'b1);
    chk("rearm_period", 32'(bus.period), 32'd8);
    chk("rearm_err",    32'(bus.err),    32'd0);
    chk("rearm_locked", 32'(bus.locked), 32'd1);
    finish_period(8);
    cyc(1'b1);
    chk("rearm_good_err", 32'(bus.err), 32'd0);
    finish_period(8);

    // Reset coincident with a rise while locked.
    rst = 1'b1;
    cyc(1'b1);
    chk("mid_rst_ctr",    32'(bus.ctr),    32'd0);
    chk("mid_rst_phase0", 32'(bus.phase0), 32'd1);
    chk("mid_rst_locked", 32'(bus.locked), 32'd0);
    chk("mid_rst_period", 32'(bus.period), 32'd0);
    chk("mid_rst_err",    32'(bus.err),    32'd0);
`ifdef PLL_SYNC_TRACKER_ERR_CNT_EN
    chk("mid_rst_err_cnt", 32'(bus.err_cnt), 32'd0);
`endif
    rst = 1'b0;
    repeat (7) cyc(1'b0);
    for (int j = 0; j <= 4; j++) begin
      cyc(1'b1);
      chk("post_rst_locked", 32'(bus.locked), (j == 4) ? 32'd1 : 32'd0);
      if (j == 0) chk("post_rst_first_period", 32'(bus.period), 32'd0);
      finish_period((j == 4) ? 7 : 8);
    end

    // Three bad periods of 7 after reset.
    cyc(1'b1);
    chk("bad1_err",    32'(bus.err),    32'd1);
    chk("bad1_period", 32'(bus.period), 32'd7);
    chk("bad1_locked", 32'(bus.locked), 32'd1);
    finish_period(7);
    cyc(1'b1);
    chk("bad2_locked", 32'(bus.locked), 32'd0);
    finish_period(7);
    cyc(1'b1);
    chk("bad3_err", 32'(bus.err), 32'd1);
`ifdef PLL_SYNC_TRACKER_ERR_CNT_EN
    chk("bad3_err_cnt", 32'(bus.err_cnt), 32'd3);
`endif
    cyc(1'b0);
    chk("bad3_err_clear", 32'(bus.err), 32'd0);
    chk("total_err_pulses", 32'(err_seen), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
